shift_deserializer: RTL and testbench

//  - Receive end of the universal shift register's serial output: collects a 1-bit stream into WIDTH-bit words.
//  - Bit order per word: MSB-first or LSB-first.
//  - Delivers each word through a one-entry output buffer with valid/ready handshake.
//  - Sits between a serial link driven by a shift register and a parallel consumer.

---
 rtl/shift_deserializer.sv | 147 ++++++++++++++
 tb/tb_shift_deserializer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_deserializer.sv
// shift_deserializer: collects a 1-bit serial stream into WIDTH-bit words.
// Each word can be sent MSB-first or LSB-first. Finished words go to a
// one-entry valid/ready output buffer. If a word finishes while that buffer
// is still full, the word is dropped and a sticky overrun flag is set.
// Optional feature: define PARITY_EN to expect one even-parity bit after each
// word. The check result is reported on parity_err alongside dout.
module shift_deserializer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             dir,
  input  logic             sync,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overrun,
  input  logic             ovr_clr,
  output logic             parity_err
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {COLLECT = 1'b0, PAR = 1'b1} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] shreg, shreg_next;
  logic [CW-1:0]    bit_cnt, cnt_next, cnt_eff;
  logic             dir_l, dir_l_next, dir_eff;
  logic             data_bit;
  // done is a one-cycle pulse: shreg holds a finished word that is waiting
  // to enter the output buffer.
  logic             done, done_next;
  logic             load, drop;
`ifdef PARITY_EN
  logic             par_bad, par_bad_next;
`endif

  // State register; sync and reset both return to collecting data bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= COLLECT;
    else      state <= state_next;
  end

  // Next-state, shift and bit-count logic.
  always_comb begin
    state_next = state;
    shreg_next = shreg;
    cnt_next   = bit_cnt;
    dir_l_next = dir_l;
    done_next  = 1'b0;
`ifdef PARITY_EN
    par_bad_next = 1'b0;
`endif
    // A sync makes the bit on this edge bit 0 of a fresh word.
    cnt_eff  = sync ? '0 : bit_cnt;
    data_bit = sync || (state == COLLECT);
    // Direction is taken live on the first bit, then held for the rest of the word.
    dir_eff  = (cnt_eff == '0) ? dir : dir_l;

    if (sync) begin
      state_next = COLLECT;
      cnt_next   = '0;
    end

    if (sin_valid) begin
      if (data_bit) begin
        dir_l_next = dir_eff;
        shreg_next = dir_eff ? {sin, shreg[WIDTH-1:1]} : {shreg[WIDTH-2:0], sin};
        if (cnt_eff == LAST) begin
          cnt_next = '0;
`ifdef PARITY_EN
          state_next = PAR;
`else
          done_next = 1'b1;
`endif
        end else begin
          cnt_next = cnt_eff + 1'b1;
        end
      end
`ifdef PARITY_EN
      else begin
        // The parity bit is not shifted in; it only qualifies the held word.
        done_next    = 1'b1;
        par_bad_next = (^shreg) ^ sin;
        state_next   = COLLECT;
      end
`endif
    end
  end

  // Shift register, bit counter, latched direction and completion pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
      dir_l   <= 1'b0;
      done    <= 1'b0;
    end else begin
      shreg   <= shreg_next;
      bit_cnt <= cnt_next;
      dir_l   <= dir_l_next;
      done    <= done_next;
    end
  end

  // A finished word enters the buffer when the buffer is empty or is being
  // drained on this same edge; otherwise the word is lost.
  assign load = done && (!dout_valid || dout_ready);
  assign drop = done && !load;

  // Output buffer, handshake and sticky overrun (a new drop beats a clear).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (load) begin
        dout       <= shreg;
        dout_valid <= 1'b1;
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end
      if (drop)         overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;
    end
  end

`ifdef PARITY_EN
  // Parity result is captured with the word and tracks dout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      par_bad <= par_bad_next;
      if (load) parity_err <= par_bad;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_shift_deserializer.sv
// Testbench for shift_deserializer.
// Part 1 runs directed table vectors and hand-written corner sequences.
// Part 2 drives randomized traffic. Every cycle, the outputs are compared
// against a word-level reference model held in this file.
module tb_shift_deserializer;
  localparam int W = 16;
`ifdef PARITY_EN
  localparam bit PB = 1'b1;
`else
  localparam bit PB = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, sin, sin_valid, dir, sync, dout_ready, ovr_clr;
  logic [W-1:0] dout;
  logic         dout_valid, overrun, parity_err;

  always #5 clk = ~clk;

  shift_deserializer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .dir(dir),
    .sync(sync), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .overrun(overrun), .ovr_clr(ovr_clr), .parity_err(parity_err)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state: bits received for the current word, the word
  // waiting to be handed over, the output buffer, and the overrun flag.
  bit           m_bits[$];
  bit           m_dir;
  bit           m_expect_par;
  logic [W-1:0] m_held;
  bit           m_pend;
  logic [W-1:0] m_pw;
  bit           m_pp;
  bit           m_bv;
  logic [W-1:0] m_bd;
  bit           m_bp;
  bit           m_ovr;
  logic [W-1:0] got[$];   // words observed crossing the handshake

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_bits.delete();
    m_dir = 0; m_expect_par = 0; m_held = '0;
    m_pend = 0; m_pw = '0; m_pp = 0;
    m_bv = 0; m_bd = '0; m_bp = 0; m_ovr = 0;
  endfunction

  // Advances the model by one clock, using the input values present before the edge.
  function automatic void model_step();
    bit           drop;
    logic [W-1:0] w;
    drop = 0;
    if (m_pend) begin
      if (!m_bv || dout_ready) begin m_bv = 1; m_bd = m_pw; m_bp = m_pp; end
      else drop = 1;
    end else if (m_bv && dout_ready) begin
      m_bv = 0;
    end
    if (drop) m_ovr = 1;
    else if (ovr_clr) m_ovr = 0;
    m_pend = 0;
    if (sync) begin m_bits.delete(); m_expect_par = 0; end
    if (sin_valid) begin
      if (m_expect_par) begin
        m_pend = 1; m_pw = m_held; m_pp = (^m_held) ^ sin; m_expect_par = 0;
      end else begin
        if (m_bits.size() == 0) m_dir = dir;
        m_bits.push_back(sin);
        if (m_bits.size() == W) begin
          // Build the word from the bit arrival order.
          w = '0;
          for (int i = 0; i < W; i++)
            if (m_bits[i]) w = w + (m_dir ? (W'(1) << i) : (W'(1) << (W - 1 - i)));
          m_bits.delete();
          if (PB) begin m_held = w; m_expect_par = 1; end
          else begin m_pend = 1; m_pw = w; m_pp = 0; end
        end
      end
    end
  endfunction

  // One clock: record any handshake, step the model, then compare all outputs.
  task automatic cycle();
    if (rst && dout_valid && dout_ready) got.push_back(dout);
    if (!rst) model_reset();
    else model_step();
    @(posedge clk);
    #1;
    chk("dout_valid", {15'd0, dout_valid}, {15'd0, m_bv});
    chk("dout", dout, m_bd);
    chk("overrun", {15'd0, overrun}, {15'd0, m_ovr});
    chk("parity_err", {15'd0, parity_err}, {15'd0, m_bp});
  endtask

  task automatic idle(input int n);
    sin_valid = 0; sync = 0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Sends one word back-to-back. d selects the bit order and the value of dir
  // on the first bit; toggle flips dir on odd bits. sync_first raises sync on
  // bit 0. pbit is the parity bit, sent only in a parity build.
  task automatic send_word(input logic [W-1:0] w, input bit d, input bit toggle,
                           input bit sync_first, input bit pbit);
    for (int i = 0; i < W; i++) begin
      sin       = d ? w[i] : w[W-1-i];
      sin_valid = 1;
      dir       = (toggle && (i % 2 == 1)) ? ~d : d;
      sync      = sync_first && (i == 0);
      cycle();
    end
    sync = 0;
    if (PB) begin sin = pbit; sin_valid = 1; cycle(); end
    sin_valid = 0;
  endtask

  typedef struct {
    logic [W-1:0] word;
    bit           d;
    bit           toggle;
    logic [W-1:0] exp;
  } vec_t;

  vec_t tbl[6];
  logic [W-1:0] junk;

  initial begin
    tbl[0] = '{16'hCFC0, 1'b0, 1'b0, 16'hCFC0};
    tbl[1] = '{16'hCFC0, 1'b1, 1'b0, 16'hCFC0};
    tbl[2] = '{16'hCFC0, 1'b1, 1'b1, 16'hCFC0};
    tbl[3] = '{16'h1234, 1'b0, 1'b1, 16'h1234};
    tbl[4] = '{16'hFFFF, 1'b1, 1'b0, 16'hFFFF};
    tbl[5] = '{16'h0001, 1'b0, 1'b0, 16'h0001};

    rst = 0; sin = 0; sin_valid = 0; dir = 0; sync = 0; dout_ready = 0; ovr_clr = 0;
    model_reset();
    cycle(); cycle();
    chk("reset_valid", {15'd0, dout_valid}, 16'd0);
    chk("reset_dout", dout, 16'd0);
    rst = 1;
    idle(2);

    // Table vectors: each word must appear one cycle after its last bit, for one cycle.
    dout_ready = 1;
    for (int v = 0; v < 6; v++) begin
      send_word(tbl[v].word, tbl[v].d, tbl[v].toggle, 1'b0, ^tbl[v].word);
      chk("vec_valid_early", {15'd0, dout_valid}, 16'd0);
      idle(1);
      chk("vec_valid", {15'd0, dout_valid}, 16'd1);
      chk("vec_dout", dout, tbl[v].exp);
      idle(1);
      chk("vec_valid_drop", {15'd0, dout_valid}, 16'd0);
      $display("vector %0d: dir=%0d toggle=%0d dout=%h", v, tbl[v].d, tbl[v].toggle, dout);
    end

    // Backpressure: the second word is dropped and the first is kept.
    dout_ready = 0;
    send_word(16'hAAAA, 1'b0, 1'b0, 1'b0, 1'b0);
    send_word(16'h5555, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    chk("bp_valid", {15'd0, dout_valid}, 16'd1);
    chk("bp_dout", dout, 16'hAAAA);
    chk("bp_overrun", {15'd0, overrun}, 16'd1);
    ovr_clr = 1; cycle(); ovr_clr = 0;
    chk("bp_ovr_clr", {15'd0, overrun}, 16'd0);
    $display("backpressure: dout=%h overrun cleared", dout);
    dout_ready = 1; idle(2);

    // Back-to-back words with ready held high: both are delivered, with no overrun.
    got.delete();
    send_word(16'h1357, 1'b0, 1'b0, 1'b0, ^16'h1357);
    send_word(16'h9BDF, 1'b1, 1'b0, 1'b0, ^16'h9BDF);
    idle(3);
    chk("b2b_count", 16'(got.size()), 16'd2);
    if (got.size() == 2) begin
      chk("b2b_word0", got[0], 16'h1357);
      chk("b2b_word1", got[1], 16'h9BDF);
    end
    chk("b2b_overrun", {15'd0, overrun}, 16'd0);
    $display("back-to-back: %0d words delivered", got.size());

    // Sync: after 7 junk bits, a sync restarts the word.
    got.delete();
    junk = 16'h007F;
    for (int i = 0; i < 7; i++) begin sin = junk[i]; sin_valid = 1; dir = 1; cycle(); end
    send_word(16'h1234, 1'b0, 1'b0, 1'b1, ^16'h1234);
    idle(2);
    chk("sync_count", 16'(got.size()), 16'd1);
    if (got.size() == 1) chk("sync_word", got[0], 16'h1234);
    $display("sync: dout=%h", dout);

`ifdef PARITY_EN
    send_word(16'h0001, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1);
    chk("par_good_dout", dout, 16'h0001);
    chk("par_good", {15'd0, parity_err}, 16'd0);
    send_word(16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    chk("par_bad_dout", dout, 16'h0001);
    chk("par_bad", {15'd0, parity_err}, 16'd1);
    $display("parity: err flag=%0d on bad parity", parity_err);
    idle(1);
`endif

    // Asynchronous reset while a word is buffered and another is half received.
    dout_ready = 0;
    send_word(16'hC3C3, 1'b0, 1'b0, 1'b0, ^16'hC3C3);
    for (int i = 0; i < 5; i++) begin sin = 1; sin_valid = 1; cycle(); end
    rst = 0;
    #2;
    chk("arst_valid", {15'd0, dout_valid}, 16'd0);
    chk("arst_dout", dout, 16'd0);
    chk("arst_overrun", {15'd0, overrun}, 16'd0);
    chk("arst_parity", {15'd0, parity_err}, 16'd0);
    sin_valid = 0;
    cycle();
    rst = 1;
    cycle();
    got.delete();
    dout_ready = 1;
    send_word(16'hBEEF, 1'b0, 1'b0, 1'b0, ^16'hBEEF);
    idle(2);
    chk("arst_clean_count", 16'(got.size()), 16'd1);
    if (got.size() == 1) chk("arst_clean_word", got[0], 16'hBEEF);
    $display("async reset: first word after release=%h", dout);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      sin        = 1'($urandom_range(0, 1));
      sin_valid  = ($urandom_range(0, 99) < 70);
      dir        = 1'($urandom_range(0, 1));
      sync       = ($urandom_range(0, 99) < 2);
      dout_ready = ($urandom_range(0, 99) < 60);
      ovr_clr    = ($urandom_range(0, 99) < 3);
      rst        = ($urandom_range(0, 999) >= 3);
      cycle();
    end
    rst = 1; ovr_clr = 0; dout_ready = 1;
    idle(3);
    $display("random: 3000 cycles applied");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
